// File: rtl/riscmakers_dcache_data_array_if.sv
// -----------------------------------------------------------------------------
// riscmakers_dcache_data_array_if
//
// Request/response bundle between the dcache controller (master) and the
// multi-way data array (slave). Signal names keep the array's port naming, so
// the _i/_o suffixes are from the array's point of view.
//
// Parameters: DATA_WIDTH (line width in bits), NUM_WORDS (lines per way),
//             NUM_WAYS (number of ways).
// Read side : rd_req_i, rd_addr_i  -> rd_gnt_o, rd_valid_o, rd_data_o
//             rd_data_o packs way w at [w*DATA_WIDTH +: DATA_WIDTH].
// Write side: wr_req_i, wr_way_i, wr_addr_i, wr_be_i, wr_data_i -> wr_gnt_o
// -----------------------------------------------------------------------------
interface riscmakers_dcache_data_array_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned NUM_WAYS   = 4
);
  localparam int unsigned ADDR_W = $clog2(NUM_WORDS);
  localparam int unsigned BE_W   = DATA_WIDTH / 8;

  logic                           rd_req_i;
  logic [ADDR_W-1:0]              rd_addr_i;
  logic                           rd_gnt_o;
  logic                           rd_valid_o;
  logic [NUM_WAYS*DATA_WIDTH-1:0] rd_data_o;

  logic                           wr_req_i;
  logic [NUM_WAYS-1:0]            wr_way_i;
  logic [ADDR_W-1:0]              wr_addr_i;
  logic [BE_W-1:0]                wr_be_i;
  logic [DATA_WIDTH-1:0]          wr_data_i;
  logic                           wr_gnt_o;

  modport slave (
    input  rd_req_i, rd_addr_i, wr_req_i, wr_way_i, wr_addr_i, wr_be_i, wr_data_i,
    output rd_gnt_o, rd_valid_o, rd_data_o, wr_gnt_o
  );

  modport master (
    output rd_req_i, rd_addr_i, wr_req_i, wr_way_i, wr_addr_i, wr_be_i, wr_data_i,
    input  rd_gnt_o, rd_valid_o, rd_data_o, wr_gnt_o
  );
endinterface

// File: rtl/riscmakers_dcache_data_array.sv
// -----------------------------------------------------------------------------
// riscmakers_dcache_data_array
//
// Multi-way simple-dual-port data store for the write-through dcache. All ways
// share one index; a read returns every way in parallel one cycle later, a
// write updates the selected ways under a shared byte enable. Block RAM cannot
// be reset, so after every reset an init sweep writes zero to one index per
// cycle (NUM_WORDS cycles) and requests are refused until it completes.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   init_busy_o  high while the zeroing sweep runs
//   bus          riscmakers_dcache_data_array_if.slave (read/write channels)
//
// Compile option:
//   RISCMAKERS_DCACHE_DATA_BYPASS_EN  defined   -> same-index read+write in one
//                                                  cycle returns the write-first
//                                                  merge
//                                     undefined -> read-first, no bypass logic
// -----------------------------------------------------------------------------
module riscmakers_dcache_data_array #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned NUM_WAYS   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic init_busy_o,
  riscmakers_dcache_data_array_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(NUM_WORDS);
  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned LINE_W = NUM_WAYS * DATA_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_idx_q, init_idx_d;
  logic              init_we_s;
  logic              init_busy_s;
  logic              rd_gnt_s;
  logic              wr_gnt_s;
  logic              rd_valid_q;
  logic [LINE_W-1:0] ram_rd_s;
  logic [LINE_W-1:0] rd_data_s;

  // State register and init sweep counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Next state: sweep one index per cycle, then stay READY until reset
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    init_we_s  = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we_s = 1'b1;
        if (init_idx_q == LAST_IDX) begin
          state_d    = ST_READY;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + ADDR_W'(1);
        end
      end
      ST_READY: begin
        state_d    = ST_READY;
        init_idx_d = '0;
      end
      default: begin
        state_d    = ST_INIT;
        init_idx_d = '0;
      end
    endcase
  end

  assign init_busy_s  = (state_q == ST_INIT);
  assign init_busy_o  = init_busy_s;
  assign rd_gnt_s     = bus.rd_req_i & ~init_busy_s;
  assign wr_gnt_s     = bus.wr_req_i & ~init_busy_s;
  assign bus.rd_gnt_o = rd_gnt_s;
  assign bus.wr_gnt_o = wr_gnt_s;

  // One storage bank per way so each maps onto its own BRAM
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  way_we_s;

    assign way_we_s = wr_gnt_s & bus.wr_way_i[w];

    // Byte-enabled write port (init sweep has priority) and read-first read port
    always_ff @(posedge clk_i) begin
      if (init_we_s) begin
        mem_q[init_idx_q] <= '0;
      end else if (way_we_s) begin
        for (int b = 0; b < BE_W; b++) begin
          if (bus.wr_be_i[b]) begin
            mem_q[bus.wr_addr_i][8*b +: 8] <= bus.wr_data_i[8*b +: 8];
          end
        end
      end
      if (rd_gnt_s) begin
        rd_q <= mem_q[bus.rd_addr_i];
      end
    end

    assign ram_rd_s[w*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  // Read valid tracks last cycle's grant; lost on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_gnt_s;
    end
  end

`ifdef RISCMAKERS_DCACHE_DATA_BYPASS_EN
  // The BRAM returns pre-write data on a same-index collision, so the write is
  // captured alongside the read and overlaid on the RAM output a cycle later.
  logic                  byp_hit_s;
  logic [NUM_WAYS-1:0]   byp_way_q;
  logic [BE_W-1:0]       byp_be_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  assign byp_hit_s = rd_gnt_s & wr_gnt_s & (bus.rd_addr_i == bus.wr_addr_i);

  // Capture the colliding write at read-request time
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byp_way_q  <= '0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else if (rd_gnt_s) begin
      byp_way_q  <= byp_hit_s ? bus.wr_way_i : '0;
      byp_be_q   <= bus.wr_be_i;
      byp_data_q <= bus.wr_data_i;
    end
  end

  // Write-first merge: enabled bytes of written ways come from the captured write
  always_comb begin
    rd_data_s = ram_rd_s;
    for (int w = 0; w < NUM_WAYS; w++) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byp_way_q[w] && byp_be_q[b]) begin
          rd_data_s[w*DATA_WIDTH + 8*b +: 8] = byp_data_q[8*b +: 8];
        end else begin
          rd_data_s[w*DATA_WIDTH + 8*b +: 8] = ram_rd_s[w*DATA_WIDTH + 8*b +: 8];
        end
      end
    end
  end
`else
  assign rd_data_s = ram_rd_s;
`endif

  assign bus.rd_valid_o = rd_valid_q;
  // Data is zero whenever it is not valid
  assign bus.rd_data_o  = rd_valid_q ? rd_data_s : '0;

endmodule

// File: tb/tb_riscmakers_dcache_data_array.sv
module tb_riscmakers_dcache_data_array;
  localparam int DW    = 128;
  localparam int NW    = 256;
  localparam int NWAYS = 4;
  localparam int LW    = NWAYS * DW;

  typedef struct {
    logic          rd_req;
    logic [7:0]    rd_addr;
    logic          wr_req;
    logic [3:0]    wr_way;
    logic [7:0]    wr_addr;
    logic [15:0]   wr_be;
    logic [DW-1:0] wr_data;
    logic          exp_valid;
    logic [LW-1:0] exp_data;
  } vec_t;

  logic clk;
  logic rst_n;
  logic init_busy;

  riscmakers_dcache_data_array_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_WAYS(NWAYS)) bus ();

  riscmakers_dcache_data_array #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_WAYS(NWAYS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .init_busy_o (init_busy),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference contents: model[way][index]
  logic [DW-1:0] model [NWAYS][NW];
  logic          ready_m;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] model_line(input logic [7:0] a);
    logic [LW-1:0] r;
    for (int w = 0; w < NWAYS; w++) r[w*DW +: DW] = model[w][a];
    return r;
  endfunction

  task automatic model_clear();
    for (int w = 0; w < NWAYS; w++)
      for (int i = 0; i < NW; i++)
        model[w][i] = '0;
  endtask

  function automatic vec_t mk(input logic rr, input logic [7:0] ra, input logic wr,
                              input logic [3:0] ww, input logic [7:0] wa, input logic [15:0] wb,
                              input logic [DW-1:0] wd, input logic ev, input logic [LW-1:0] ed);
    vec_t v;
    v.rd_req = rr; v.rd_addr = ra; v.wr_req = wr; v.wr_way = ww; v.wr_addr = wa;
    v.wr_be = wb; v.wr_data = wd; v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  // One bus cycle; entered and left 1 time unit after a rising edge.
  // use_exp selects the given expectation instead of the reference model.
  task automatic step(input logic rr, input logic [7:0] ra, input logic wr, input logic [3:0] ww,
                      input logic [7:0] wa, input logic [15:0] wb, input logic [DW-1:0] wd,
                      input logic use_exp, input logic ev, input logic [LW-1:0] ed,
                      input string name);
    logic [LW-1:0] old_line, new_line, m_data;
    logic          m_valid;
    bus.rd_req_i = rr; bus.rd_addr_i = ra;
    bus.wr_req_i = wr; bus.wr_way_i = ww; bus.wr_addr_i = wa;
    bus.wr_be_i = wb; bus.wr_data_i = wd;
    #4;
    chk($sformatf("%s_rd_gnt", name), LW'(bus.rd_gnt_o), LW'(rr & ready_m));
    chk($sformatf("%s_wr_gnt", name), LW'(bus.wr_gnt_o), LW'(wr & ready_m));
    @(posedge clk);
    old_line = model_line(ra);
    if (wr && ready_m) begin
      for (int w = 0; w < NWAYS; w++)
        if (ww[w])
          for (int b = 0; b < DW/8; b++)
            if (wb[b]) model[w][wa][8*b +: 8] = wd[8*b +: 8];
    end
    new_line = model_line(ra);
    m_valid = rr & ready_m;
`ifdef RISCMAKERS_DCACHE_DATA_BYPASS_EN
    m_data = m_valid ? new_line : '0;
`else
    m_data = m_valid ? old_line : '0;
`endif
    #1;
    chk($sformatf("%s_rd_valid", name), LW'(bus.rd_valid_o), LW'(use_exp ? ev : m_valid));
    chk($sformatf("%s_rd_data", name), bus.rd_data_o, use_exp ? ed : m_data);
  endtask

  // Runs the zeroing sweep with all requests held high; entered just after reset release
  task automatic wait_init(input string name);
    int cyc;
    int gbad;
    cyc = 0;
    gbad = 0;
    bus.rd_req_i = 1'b1; bus.wr_req_i = 1'b1; bus.wr_way_i = '1; bus.wr_be_i = '1;
    bus.wr_data_i = '1; bus.rd_addr_i = 8'd0; bus.wr_addr_i = 8'd0;
    while (cyc < 4*NW) begin
      @(posedge clk); #1;
      cyc++;
      if (init_busy !== 1'b1) break;
      if (bus.rd_gnt_o !== 1'b0 || bus.wr_gnt_o !== 1'b0) gbad++;
      bus.wr_addr_i = cyc[7:0];
      bus.rd_addr_i = cyc[7:0];
    end
    bus.rd_req_i = 1'b0; bus.wr_req_i = 1'b0; bus.wr_way_i = '0; bus.wr_be_i = '0;
    bus.wr_data_i = '0; bus.rd_addr_i = 8'd0; bus.wr_addr_i = 8'd0;
    chk($sformatf("%s_cycles", name), LW'(cyc), LW'(NW));
    chk($sformatf("%s_gnt_during_init", name), LW'(gbad), LW'(0));
    model_clear();
    ready_m = 1'b1;
  endtask

  initial begin
    logic [LW-1:0] e5, e9, e9_same, e1, e2, e3, zero;
    logic [DW-1:0] aa, d11, d22, d33, dff, d77;
    vec_t vecs[17];

    aa = {16{8'hAA}}; d11 = {16{8'h11}}; d22 = {16{8'h22}}; d33 = {16{8'h33}};
    dff = {16{8'hFF}}; d77 = {16{8'h77}}; zero = '0;
    e5 = '0; e5[2*DW +: 64] = {8{8'hAA}};
    e9 = '0; e9[7:0] = 8'h5C;
`ifdef RISCMAKERS_DCACHE_DATA_BYPASS_EN
    e9_same = e9;
`else
    e9_same = '0;
`endif
    e1 = '0; e1[1*DW +: DW] = d11;
    e2 = '0; e2[3*DW + 32 +: 32] = 32'h2222_2222; e2[3*DW + 96 +: 32] = 32'h2222_2222;
    e3 = '0; e3[0 +: DW] = d33; e3[3*DW +: DW] = d33;

    vecs[0]  = mk(1'b1, 8'd0,   1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b1, zero);
    vecs[1]  = mk(1'b1, 8'd127, 1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b1, zero);
    vecs[2]  = mk(1'b1, 8'd255, 1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b1, zero);
    vecs[3]  = mk(1'b0, 8'd0,   1'b1, 4'b0100, 8'd5, 16'h00FF, aa,        1'b0, zero);
    vecs[4]  = mk(1'b1, 8'd5,   1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b1, e5);
    vecs[5]  = mk(1'b1, 8'd9,   1'b1, 4'b0001, 8'd9, 16'h0001, 128'h5C,   1'b1, e9_same);
    vecs[6]  = mk(1'b1, 8'd9,   1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b1, e9);
    vecs[7]  = mk(1'b0, 8'd0,   1'b1, 4'b0010, 8'd1, 16'hFFFF, d11,       1'b0, zero);
    vecs[8]  = mk(1'b0, 8'd0,   1'b1, 4'b1000, 8'd2, 16'hF0F0, d22,       1'b0, zero);
    vecs[9]  = mk(1'b1, 8'd1,   1'b1, 4'b1001, 8'd3, 16'hFFFF, d33,       1'b1, e1);
    vecs[10] = mk(1'b1, 8'd2,   1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b1, e2);
    vecs[11] = mk(1'b1, 8'd3,   1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b1, e3);
    vecs[12] = mk(1'b0, 8'd3,   1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b0, zero);
    vecs[13] = mk(1'b0, 8'd0,   1'b1, 4'b1111, 8'd7, 16'h0000, dff,       1'b0, zero);
    vecs[14] = mk(1'b0, 8'd0,   1'b1, 4'b0000, 8'd7, 16'hFFFF, dff,       1'b0, zero);
    vecs[15] = mk(1'b1, 8'd7,   1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b1, zero);
    vecs[16] = mk(1'b0, 8'd0,   1'b0, 4'h0,    8'd0, 16'h0000, '0,        1'b0, zero);

    // Reset state, with requests asserted
    rst_n = 1'b0; ready_m = 1'b0;
    bus.rd_req_i = 1'b1; bus.wr_req_i = 1'b1; bus.wr_way_i = '1; bus.wr_be_i = '1;
    bus.wr_data_i = dff; bus.rd_addr_i = 8'd0; bus.wr_addr_i = 8'd0;
    #2;
    chk("rst_busy",     LW'(init_busy),      LW'(1));
    chk("rst_rd_valid", LW'(bus.rd_valid_o), LW'(0));
    chk("rst_rd_data",  bus.rd_data_o,       zero);
    chk("rst_rd_gnt",   LW'(bus.rd_gnt_o),   LW'(0));
    chk("rst_wr_gnt",   LW'(bus.wr_gnt_o),   LW'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("init");

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rd_req, vecs[i].rd_addr, vecs[i].wr_req, vecs[i].wr_way, vecs[i].wr_addr,
           vecs[i].wr_be, vecs[i].wr_data, 1'b1, vecs[i].exp_valid, vecs[i].exp_data,
           $sformatf("vec%0d", i));
    end

    // Random traffic over a small index range to provoke collisions
    for (int i = 0; i < 300; i++) begin
      logic [15:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, 4'($urandom), 8'($urandom_range(0, 15)), rb,
           {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0, "rand");
    end

    // Reset in the middle of a valid read
    step(1'b0, 8'd0, 1'b1, 4'b1111, 8'd5, 16'hFFFF, d77, 1'b0, 1'b0, '0, "pre_rst_wr");
    step(1'b1, 8'd5, 1'b0, 4'h0,    8'd0, 16'h0000, '0,  1'b0, 1'b0, '0, "pre_rst_rd");
    rst_n = 1'b0;
    ready_m = 1'b0;
    #1;
    chk("midrst_rd_valid", LW'(bus.rd_valid_o), LW'(0));
    chk("midrst_busy",     LW'(init_busy),      LW'(1));
    chk("midrst_rd_data",  bus.rd_data_o,       zero);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("reinit");
    step(1'b1, 8'd5, 1'b0, 4'h0, 8'd0, 16'h0000, '0, 1'b1, 1'b1, zero, "post_rst_rd5");
    step(1'b0, 8'd0, 1'b0, 4'h0, 8'd0, 16'h0000, '0, 1'b1, 1'b0, zero, "post_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscmakers_dcache_data_array.md
# riscmakers_dcache_data_array

Multi-way, simple-dual-port data array for the write-through data cache. It replaces the single-way store with a parametrised bank of `NUM_WAYS` ways that all share one index. A read returns every way in parallel so the controller can select the way after the tag compare, and a write carries a per-byte enable for one or more ways. Because FPGA block RAM cannot be reset, a built-in initialisation state machine zeroes every word after reset. The block sits between the dcache controller/miss unit and the BRAM primitives.

## Interface
- `DATA_WIDTH`, default 128: cache line width in bits; must be a multiple of 8.
- `NUM_WORDS`, default 256: lines per way; must be a power of 2, ≥2.
- `NUM_WAYS`, default 4: number of ways, ≥1.
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `init_busy_o` out, 1: high while the zeroing sweep runs.
- `rd_req_i` in, 1: read request.
- `rd_addr_i` in, `$clog2(NUM_WORDS)`: read index.
- `rd_gnt_o` out, 1: read accepted this cycle; equals `rd_req_i & ~init_busy_o`.
- `rd_valid_o` out, 1: `rd_data_o` valid.
- `rd_data_o` out, `NUM_WAYS*DATA_WIDTH`: way w occupies bits `[w*DATA_WIDTH +: DATA_WIDTH]`.
- `wr_req_i` in, 1: write request.
- `wr_way_i` in, `NUM_WAYS`: way select; more than one bit set writes all selected ways.
- `wr_addr_i` in, `$clog2(NUM_WORDS)`: write index.
- `wr_be_i` in, `DATA_WIDTH/8`: byte enable, shared by the selected ways.
- `wr_data_i` in, `DATA_WIDTH`: write data.
- `wr_gnt_o` out, 1: write accepted; equals `wr_req_i & ~init_busy_o`.

## Operation
- FSM states:
  - INIT: entered on reset. A counter `init_idx` starts at 0 and writes all-zero to `init_idx` in every way, one index per cycle. After `init_idx == NUM_WORDS-1` is written, the FSM moves to READY; it takes exactly `NUM_WORDS` cycles.
  - READY: serves requests. It leaves READY only on reset.
- While in INIT, `init_busy_o` is 1, both grants are 0, and requests are dropped with no side effects.
- Write: when granted, on the clock edge, byte b of each selected way at `wr_addr_i` takes `wr_data_i[8b+:8]` if `wr_be_i[b]` is set. Unselected bytes and ways are unchanged. If `wr_be_i` or `wr_way_i` is all zero, the write is granted but is a no-op.
- Read: when granted, the index is registered. The array read of all ways appears on the next cycle.
- `rd_data_o` is forced to zero whenever `rd_valid_o` is 0. It holds the last read data while `rd_valid_o` is 1.
- Read and write in the same cycle to different indices: both proceed independently.
- Read and write in the same cycle to the same index: the result depends on the compile option; see Configuration.
- Reset asserted mid-operation: outputs return to their reset values immediately, the FSM returns to INIT with `init_idx` at 0, and any in-flight read is lost. Array contents are undefined until the new sweep completes.

## Timing
- Reset values:
  - `init_busy_o` = 1.
  - `rd_valid_o` = 0.
  - `rd_data_o` = 0.
  - `rd_gnt_o` and `wr_gnt_o` = 0 (combinational, gated by busy).
- Init: `init_busy_o` falls after the `NUM_WORDS`-th clock edge following reset release.
- Read latency is 1: a grant at edge N gives `rd_valid_o` = 1 and data after edge N+1. `rd_valid_o` stays 1 until the cycle after a cycle with no read grant, then drops to 0.
- Reads and writes are both fully pipelined at one per cycle.
- Write-to-read: a read granted in the cycle after a write edge sees the new data.

## Configuration
- `RISCMAKERS_DCACHE_DATA_BYPASS_EN` defined: a same-index read and write in the same cycle return the write-first merge. For each written way, enabled bytes come from `wr_data_i` and the rest from the old contents. Unwritten ways return old data. The merge is captured in a register at request time and muxed onto the output.
- Undefined: same-index read and write return the old (pre-write) contents for all ways (read-first), and no bypass logic is built.

## Test plan
- Reset, then count cycles: `init_busy_o` = 1 for exactly `NUM_WORDS` = 256 cycles. Then read indices 0, 127 and 255: all ways read 0.
- Write way 2, index 5, `wr_be` = 16'h00FF, data 128'hAAAA…; next cycle read index 5: way 2 low 8 bytes = AA, high bytes = 0, other ways 0.
- Same-cycle read/write to index 9, way 0, `wr_be` = 16'h0001, data 8'h5C, old value 0: with the macro, way 0 byte 0 = 5C; without it, 0. The next read returns 5C in either build.
- Back-to-back reads of indices 1, 2, 3 on consecutive cycles: `rd_valid_o` stays 1 for 3 cycles with matching data, then 0 with `rd_data_o` = 0.
- Requests during INIT: `rd_req_i` = `wr_req_i` = 1 with data FF: grants are 0, and after init the array reads 0.
- Assert `rst_ni` mid-stream while `rd_valid_o` = 1: `rd_valid_o` is 0 and `init_busy_o` is 1 immediately. After a full 256-cycle sweep, a previously written index reads 0.
